// File: rtl/mult_ctrl_pkg.sv
// Shared types and defaults for the ROM -> multiplier -> RAM batch sequencer.
// Holds the state encoding, the batch-size defaults and the n_jobs saturation helper.
package mult_ctrl_pkg;

    localparam int ADDR_W_DEF   = 3;
    localparam int MAX_JOBS_DEF = 8;

    // st_out encodings are visible on board LEDs; keep them fixed.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_LAUNCH = 4'd2,
        ST_WAIT   = 4'd3,
        ST_WRITE  = 4'd4,
        ST_NEXT   = 4'd5,
        ST_FIN    = 4'd6
    } state_t;

    // Clamp a requested batch size to the address space.
    function automatic logic [31:0] sat_jobs(
        input logic [31:0] n,
        input logic [31:0] max_n
    );
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/mult_batch_ctrl.sv
// Batch sequencer: for job i reads ROM[a_base+i], ROM[b_base+i], launches the
// multiplier, waits for mul_done and writes RAM[r_base+i]; repeats for n jobs.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start, abort                     batch request / cancel
//   n_jobs, a_base, b_base, r_base   batch setup, sampled with start
//   rom_en, rom_adr1, rom_adr2       ROM read strobe and operand addresses
//   mul_start, mul_done              multiplier launch pulse / product valid
//   ram_we, ram_adr                  RAM write strobe and address
//   busy, done, jobs_done, st_out    status
module mult_batch_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_JOBS = MAX_JOBS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   n_jobs,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] r_base,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_adr1,
    output logic [ADDR_W-1:0] rom_adr2,
    output logic              mul_start,
    input  logic              mul_done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_adr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   jobs_done,
    output logic [3:0]        st_out
);

    localparam int NW = ADDR_W + 1;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W-1:0] r_a;
    logic [ADDR_W-1:0] r_b;
    logic [ADDR_W-1:0] r_r;
    logic [ADDR_W-1:0] r_i;
    logic [ADDR_W:0]   r_jobs;
    logic [ADDR_W-1:0] r_rom1;
    logic [ADDR_W-1:0] r_rom2;
    logic [ADDR_W-1:0] r_ram;

    logic [ADDR_W:0]   w_n_sat;
    logic [ADDR_W-1:0] w_rom1;
    logic [ADDR_W-1:0] w_rom2;
    logic [ADDR_W-1:0] w_ram;
    logic              w_last;

    assign w_n_sat = NW'(sat_jobs(32'(n_jobs), MAX_JOBS));

    // Address sums wrap naturally at 2**ADDR_W.
    assign w_rom1 = r_a + r_i;
    assign w_rom2 = r_b + r_i;
    assign w_ram  = r_r + r_i;
    assign w_last = ({1'b0, r_i} == (r_n - NW'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_r     <= '0;
            r_i     <= '0;
            r_jobs  <= '0;
            r_rom1  <= '0;
            r_rom2  <= '0;
            r_ram   <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n    <= w_n_sat;
                        r_a    <= a_base;
                        r_b    <= b_base;
                        r_r    <= r_base;
                        r_i    <= '0;
                        r_jobs <= '0;
                    end
                end
                ST_FETCH: begin
                    r_rom1 <= w_rom1;
                    r_rom2 <= w_rom2;
                end
                ST_WRITE: begin
                    // The write issued this cycle counts even if aborted.
                    r_ram  <= w_ram;
                    r_jobs <= r_jobs + NW'(1);
                end
                ST_NEXT: begin
                    if (!w_last) begin
                        r_i <= r_i + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        rom_en    = 1'b0;
        mul_start = 1'b0;
        ram_we    = 1'b0;
        done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = (w_n_sat == '0) ? ST_FIN : ST_FETCH;
                end
            end
            ST_FETCH: begin
                rom_en = 1'b1;
                w_next = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                // mul_done seen here is stale; WAIT is always visited.
                mul_start = 1'b1;
                w_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_done) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ram_we = 1'b1;
                w_next = ST_NEXT;
            end
            ST_NEXT: begin
                w_next = w_last ? ST_FIN : ST_FETCH;
            end
            ST_FIN: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (abort && (r_state != ST_IDLE) && (r_state != ST_FIN)) begin
            w_next = ST_IDLE;
        end
    end

    // Addresses show the live sum in their strobe cycle, then hold.
    always_comb begin
        rom_adr1 = (r_state == ST_FETCH) ? w_rom1 : r_rom1;
        rom_adr2 = (r_state == ST_FETCH) ? w_rom2 : r_rom2;
        ram_adr  = (r_state == ST_WRITE) ? w_ram : r_ram;
    end

    assign busy      = (r_state != ST_IDLE);
    assign jobs_done = r_jobs;
    assign st_out    = r_state;

endmodule

// File: tb/tb_mult_batch_ctrl.sv
// Self-checking bench for mult_batch_ctrl with a fixed-latency multiplier model
// and scoreboards for ROM fetch and RAM write addresses.
module tb_mult_batch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] n_jobs;
    logic [2:0] a_base;
    logic [2:0] b_base;
    logic [2:0] r_base;
    logic       rom_en;
    logic [2:0] rom_adr1;
    logic [2:0] rom_adr2;
    logic       mul_start;
    logic       mul_done;
    logic       ram_we;
    logic [2:0] ram_adr;
    logic       busy;
    logic       done;
    logic [3:0] jobs_done;
    logic [3:0] st_out;

    mult_batch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .n_jobs    (n_jobs),
        .a_base    (a_base),
        .b_base    (b_base),
        .r_base    (r_base),
        .rom_en    (rom_en),
        .rom_adr1  (rom_adr1),
        .rom_adr2  (rom_adr2),
        .mul_start (mul_start),
        .mul_done  (mul_done),
        .ram_we    (ram_we),
        .ram_adr   (ram_adr),
        .busy      (busy),
        .done      (done),
        .jobs_done (jobs_done),
        .st_out    (st_out)
    );

    always #5 clk = ~clk;

    // Multiplier model: mul_done pulses in the 5th cycle after the launch
    // cycle, giving a 9-cycle job period.
    logic       md_force = 1'b0;
    logic [3:0] mcnt;
    always @(posedge clk) begin
        if (rst) mcnt <= '0;
        else if (mul_start) mcnt <= 4'd5;
        else if (mcnt != 0) mcnt <= mcnt - 4'd1;
    end
    assign mul_done = md_force | (mcnt == 4'd1);

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [5:0] exp_rom[$];
    logic [2:0] exp_ram[$];
    int         fetch_cyc[$];
    int         cyc = 0;
    int         n_done = 0;
    int         n_mst = 0;

    always @(negedge clk) begin
        cyc++;
        if (rom_en) begin
            fetch_cyc.push_back(cyc);
            if (exp_rom.size() == 0) check("rom_unexpected", 1, 0);
            else check("rom_pair", {rom_adr1, rom_adr2}, exp_rom.pop_front());
        end
        if (ram_we) begin
            if (exp_ram.size() == 0) check("ram_unexpected", 1, 0);
            else check("ram_adr", ram_adr, exp_ram.pop_front());
        end
        if (done) n_done++;
        if (mul_start) n_mst++;
    end

    task automatic clear_obs();
        fetch_cyc.delete();
        n_done = 0;
        n_mst  = 0;
    endtask

    task automatic push_jobs(input int a, input int b, input int r,
                             input int nf, input int nw);
        for (int i = 0; i < nf; i++) begin
            logic [2:0] x;
            logic [2:0] y;
            x = 3'((a + i) % 8);
            y = 3'((b + i) % 8);
            exp_rom.push_back({x, y});
        end
        for (int i = 0; i < nw; i++) exp_ram.push_back(3'((r + i) % 8));
    endtask

    task automatic start_batch(input int n, input int a, input int b, input int r);
        @(posedge clk); #1;
        n_jobs = 4'(n);
        a_base = 3'(a);
        b_base = 3'(b);
        r_base = 3'(r);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where done is high.
    task automatic wait_done(output bit ok);
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_state(input logic [3:0] st, input int nf, output bit ok);
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (st_out == st && fetch_cyc.size() == nf) begin
                ok = 1;
                break;
            end
        end
    endtask

    typedef struct {
        int n;
        int a;
        int b;
        int r;
        int exp_jobs;
        int exp_st1;
    } vec_t;

    vec_t vecs[5];
    bit   ok;

    initial begin
        vecs[0] = '{n: 3,  a: 0, b: 1, r: 2, exp_jobs: 3, exp_st1: 1};
        vecs[1] = '{n: 12, a: 6, b: 3, r: 7, exp_jobs: 8, exp_st1: 1};
        vecs[2] = '{n: 0,  a: 5, b: 5, r: 5, exp_jobs: 0, exp_st1: 6};
        vecs[3] = '{n: 8,  a: 2, b: 7, r: 4, exp_jobs: 8, exp_st1: 1};
        vecs[4] = '{n: 1,  a: 7, b: 7, r: 7, exp_jobs: 1, exp_st1: 1};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        n_jobs = '0;
        a_base = '0;
        b_base = '0;
        r_base = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_st", st_out, 0);
        check("rst_busy", busy, 0);
        check("rst_strobes", {rom_en, mul_start, ram_we, done}, 0);
        check("rst_adr", {rom_adr1, rom_adr2, ram_adr}, 0);
        check("rst_jobs", jobs_done, 0);

        // Table-driven batches.
        for (int v = 0; v < 5; v++) begin
            int nw;
            nw = (vecs[v].n > 8) ? 8 : vecs[v].n;
            clear_obs();
            push_jobs(vecs[v].a, vecs[v].b, vecs[v].r, nw, nw);
            start_batch(vecs[v].n, vecs[v].a, vecs[v].b, vecs[v].r);
            @(negedge clk);
            check("first_st", st_out, vecs[v].exp_st1);
            wait_done(ok);
            check("done_seen", ok, 1);
            check("fin_jobs", jobs_done, vecs[v].exp_jobs);
            repeat (3) @(negedge clk);
            check("done_once", n_done, 1);
            check("idle_busy", busy, 0);
            check("mul_starts", n_mst, nw);
            check("rom_left", exp_rom.size(), 0);
            check("ram_left", exp_ram.size(), 0);
            if (nw >= 2) check("period", fetch_cyc[1] - fetch_cyc[0], 9);
            exp_rom.delete();
            exp_ram.delete();
        end

        // Reset during WAIT of job 2.
        clear_obs();
        push_jobs(1, 2, 3, 3, 2);
        start_batch(4, 1, 2, 3);
        wait_state(4'd3, 3, ok);
        check("rst_reach_wait", ok, 1);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_st", st_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_we", ram_we, 0);
        check("midrst_jobs", jobs_done, 0);
        repeat (20) @(negedge clk);
        check("midrst_nodone", n_done, 0);
        check("midrst_rom_left", exp_rom.size(), 0);
        check("midrst_ram_left", exp_ram.size(), 0);
        exp_rom.delete();
        exp_ram.delete();

        // Abort during WAIT of job 1.
        clear_obs();
        push_jobs(1, 2, 3, 2, 1);
        start_batch(4, 1, 2, 3);
        wait_state(4'd3, 2, ok);
        check("abort_reach_wait", ok, 1);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_st", st_out, 0);
        check("abort_jobs", jobs_done, 1);
        repeat (20) @(negedge clk);
        check("abort_nodone", n_done, 0);
        check("abort_jobs_hold", jobs_done, 1);
        check("abort_rom_left", exp_rom.size(), 0);
        check("abort_ram_left", exp_ram.size(), 0);
        exp_rom.delete();
        exp_ram.delete();

        // Normal batch after abort.
        clear_obs();
        push_jobs(4, 0, 6, 2, 2);
        start_batch(2, 4, 0, 6);
        @(negedge clk);
        wait_done(ok);
        check("post_abort_done", ok, 1);
        check("post_abort_jobs", jobs_done, 2);
        repeat (3) @(negedge clk);
        check("post_abort_ram_left", exp_ram.size(), 0);

        // start pulsed during WAIT is dropped.
        clear_obs();
        push_jobs(3, 4, 5, 2, 2);
        start_batch(2, 3, 4, 5);
        wait_state(4'd3, 1, ok);
        check("ign_reach_wait", ok, 1);
        #1 n_jobs = 4'd5;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        wait_done(ok);
        check("ign_done", ok, 1);
        check("ign_jobs", jobs_done, 2);
        repeat (30) @(negedge clk);
        check("ign_fetches", fetch_cyc.size(), 2);
        check("ign_idle", st_out, 0);
        check("ign_done_once", n_done, 1);
        check("ign_ram_left", exp_ram.size(), 0);

        // mul_done held high through LAUNCH still visits WAIT.
        clear_obs();
        push_jobs(4, 4, 4, 1, 1);
        start_batch(1, 4, 4, 4);
        @(posedge clk); #1 md_force = 1'b1;
        @(negedge clk);
        check("md_launch", st_out, 2);
        @(negedge clk);
        check("md_wait", st_out, 3);
        @(negedge clk);
        check("md_write", st_out, 4);
        md_force = 1'b0;
        wait_done(ok);
        check("md_done", ok, 1);
        check("md_jobs", jobs_done, 1);
        repeat (10) @(negedge clk);
        check("md_ram_left", exp_ram.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
